// File: rtl/arith_pkg.sv
// Shared constants and types for the arithmetic-pipeline issue sequencer.
package arith_pkg;

  // Depth of the pipeline weight buffer: one softmax group is NUM_EXP scores.
  localparam int NUM_EXP = 8;
  localparam int CNT_W   = $clog2(NUM_EXP);

  localparam logic [1:0] MODE_EXP  = 2'b00;
  localparam logic [1:0] MODE_DIV  = 2'b01;
  localparam logic [1:0] MODE_GELU = 2'b10;
  localparam logic [1:0] MODE_AGG  = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    LD_SC,
    EXP,
    WAIT_SUM,
    DIV,
    WAIT_DIV,
    AGG,
    GELU,
    DONE
  } state_e;

endpackage

// File: rtl/arith_issuer.sv
// Issues exp/div/AGG or GeLU beats into the arithmetic pipeline, with drain
// gaps between phases so accumulator and multiplier results can settle.
module arith_issuer
  import arith_pkg::*;
#(
  parameter int DW      = 16,
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cfg_gelu,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          sc_valid,
  output logic          sc_ready,
  input  logic [DW-1:0] sc_data,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] ex_data,
  input  logic [DW-1:0] ex_psum,
  input  logic          ex_last,
  output logic          iss_valid,
  output logic [DW-1:0] iss_data,
  output logic [DW-1:0] iss_psum,
  output logic [1:0]    iss_mode
);

  localparam int TW = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_EXP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [DW-1:0]    score_buf_q [NUM_EXP];
  logic [DW-1:0]    score_buf_d [NUM_EXP];
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sc_ready_q, sc_ready_d;
  logic             ex_ready_q, ex_ready_d;
  logic             iss_valid_q, iss_valid_d;
  logic [DW-1:0]    iss_data_q, iss_data_d;
  logic [DW-1:0]    iss_psum_q, iss_psum_d;
  logic [1:0]       iss_mode_q, iss_mode_d;
  logic             sc_hs, ex_hs;

  // Handshakes are qualified by the registered ready, so the accepting state
  // and the visible ready can never disagree.
  assign sc_hs = sc_valid & sc_ready_q;
  assign ex_hs = ex_valid & ex_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    score_buf_d = score_buf_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    iss_valid_d = 1'b0;
    iss_data_d  = iss_data_q;
    iss_psum_d  = iss_psum_q;
    iss_mode_d  = iss_mode_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = cfg_gelu ? GELU : LD_SC;
        end
      end
      LD_SC: begin
        if (sc_hs) begin
          score_buf_d[cnt_q] = sc_data;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = EXP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      EXP: begin
        iss_valid_d = 1'b1;
        iss_mode_d  = MODE_EXP;
        iss_data_d  = score_buf_q[cnt_q];
        iss_psum_d  = '0;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (ADD_LAT == 0) begin
            state_d = DIV;
          end else begin
            timer_d = TW'(ADD_LAT);
            state_d = WAIT_SUM;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_SUM: begin
        // Stay exactly ADD_LAT cycles: leave on the cycle the count hits 1.
        if (timer_q <= TW'(1)) begin
          timer_d = '0;
          state_d = DIV;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DIV: begin
        iss_valid_d = 1'b1;
        iss_mode_d  = MODE_DIV;
        iss_data_d  = score_buf_q[cnt_q];
        iss_psum_d  = '0;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (MUL_LAT == 0) begin
            state_d = AGG;
          end else begin
            timer_d = TW'(MUL_LAT);
            state_d = WAIT_DIV;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DIV: begin
        if (timer_q <= TW'(1)) begin
          timer_d = '0;
          state_d = AGG;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      AGG: begin
        if (ex_hs) begin
          iss_valid_d = 1'b1;
          iss_mode_d  = MODE_AGG;
          iss_data_d  = ex_data;
          iss_psum_d  = ex_psum;
          cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
          if (ex_last) begin
            // Only a whole number of NUM_EXP groups is a legal AGG stream.
            if (cnt_q != CNT_LAST) err_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      GELU: begin
        if (ex_hs) begin
          iss_valid_d = 1'b1;
          iss_mode_d  = MODE_GELU;
          iss_data_d  = ex_data;
          iss_psum_d  = '0;
          if (ex_last) state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    sc_ready_d = (state_d == LD_SC);
    ex_ready_d = (state_d == AGG) || (state_d == GELU);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sc_ready_q  <= 1'b0;
      ex_ready_q  <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_data_q  <= '0;
      iss_psum_q  <= '0;
      iss_mode_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sc_ready_q  <= sc_ready_d;
      ex_ready_q  <= ex_ready_d;
      iss_valid_q <= iss_valid_d;
      iss_data_q  <= iss_data_d;
      iss_psum_q  <= iss_psum_d;
      iss_mode_q  <= iss_mode_d;
    end
  end

  for (genvar gi = 0; gi < NUM_EXP; gi++) begin : g_score_buf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) score_buf_q[gi] <= '0;
      else        score_buf_q[gi] <= score_buf_d[gi];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sc_ready  = sc_ready_q;
  assign ex_ready  = ex_ready_q;
  assign iss_valid = iss_valid_q;
  assign iss_data  = iss_data_q;
  assign iss_psum  = iss_psum_q;
  assign iss_mode  = iss_mode_q;

endmodule

// File: tb/tb_arith_issuer.sv
// Randomized bench for arith_issuer: a job-level model predicts the beat stream,
// phase gaps, done timing and err; a negedge monitor compares the DUT to it.
module tb_arith_issuer;
  import arith_pkg::*;

  localparam int DW      = 16;
  localparam int ADD_LAT = 2;
  localparam int MUL_LAT = 2;
  localparam int MAX_EX  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cfg_gelu = 1'b0;
  logic          sc_valid = 1'b0;
  logic [DW-1:0] sc_data = '0;
  logic          ex_valid = 1'b0;
  logic [DW-1:0] ex_data = '0;
  logic [DW-1:0] ex_psum = '0;
  logic          ex_last = 1'b0;
  logic          busy, done, err, sc_ready, ex_ready, iss_valid;
  logic [DW-1:0] iss_data, iss_psum;
  logic [1:0]    iss_mode;

  arith_issuer #(.DW(DW), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_gelu(cfg_gelu),
    .busy(busy), .done(done), .err(err),
    .sc_valid(sc_valid), .sc_ready(sc_ready), .sc_data(sc_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_data(ex_data),
    .ex_psum(ex_psum), .ex_last(ex_last),
    .iss_valid(iss_valid), .iss_data(iss_data), .iss_psum(iss_psum),
    .iss_mode(iss_mode)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Job description, written by the driver before start.
  logic [DW-1:0] job_sc [NUM_EXP];
  logic [DW-1:0] job_ed [MAX_EX];
  logic [DW-1:0] job_ep [MAX_EX];
  bit            job_gelu, job_abort;
  int            job_n;

  // Monitor-owned state: expected beats and per-job observations.
  logic [33:0] sbq [$];
  int cyc = 0;
  int first_c [4];
  int last_c [4];
  int cnt_m [4];
  int done_cnt = 0, done_cyc = 0, last_iss_cyc = 0, first_exrdy = -1;
  bit sc_rdy_bad = 0, prev_hs = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_hs = 0;
      sbq.delete();
    end else begin
      if (start && !busy) begin
        sbq.delete();
        for (int m = 0; m < 4; m++) begin
          cnt_m[m] = 0; first_c[m] = 0; last_c[m] = 0;
        end
        done_cnt = 0; first_exrdy = -1; sc_rdy_bad = 0;
        if (!job_gelu) begin
          for (int i = 0; i < NUM_EXP; i++) sbq.push_back({MODE_EXP, job_sc[i], 16'h0});
          for (int i = 0; i < NUM_EXP; i++) sbq.push_back({MODE_DIV, job_sc[i], 16'h0});
        end
        if (!job_abort)
          for (int i = 0; i < job_n; i++)
            sbq.push_back(job_gelu ? {MODE_GELU, job_ed[i], 16'h0} : {MODE_AGG, job_ed[i], job_ep[i]});
      end
      if (prev_hs) check_eq("latency", iss_valid, 1);
      if (iss_valid) begin
        if (sbq.size() == 0) check_eq("beat_expected", sbq.size(), 1);
        else check_eq("beat", {iss_mode, iss_data, iss_psum}, sbq.pop_front());
        if (iss_mode[1]) check_eq("no_bubble_fill", prev_hs, 1);
        if (cnt_m[iss_mode] == 0) first_c[iss_mode] = cyc;
        last_c[iss_mode] = cyc;
        cnt_m[iss_mode]++;
        last_iss_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("busy_at_done", busy, 0);
      end
      if (job_gelu && sc_ready) sc_rdy_bad = 1;
      if (ex_ready && first_exrdy < 0) first_exrdy = cyc;
      prev_hs = ex_valid && ex_ready;
    end
  end

  task automatic fill_rand();
    for (int i = 0; i < NUM_EXP; i++) job_sc[i] = DW'($urandom_range(0, 65535));
    for (int i = 0; i < MAX_EX; i++) begin
      job_ed[i] = DW'($urandom_range(0, 65535));
      job_ep[i] = DW'($urandom_range(0, 65535));
    end
  endtask

  // vpat: 0 = ex_valid always high, 1 = toggles every cycle, 2 = random.
  task automatic run_job(input bit gelu, input int n, input int vpat, input bit sc_gaps,
                         input bit start_in_exp, input bit abort);
    int  i, t;
    bit  v, hs;
    job_gelu = gelu; job_n = n; job_abort = abort;
    start = 1'b1; cfg_gelu = gelu;
    @(posedge clk); #1;
    start = 1'b0; cfg_gelu = ~gelu;
    check_eq("busy_after_start", busy, 1);
    check_eq("err_cleared", err, 0);
    if (!gelu) begin
      i = 0; t = 0;
      while (i < NUM_EXP && t < 200) begin
        v = !sc_gaps || ($urandom_range(0, 3) != 0);
        sc_valid = v;
        sc_data  = v ? job_sc[i] : DW'($urandom_range(0, 65535));
        hs = v && sc_ready;
        @(posedge clk); #1; t++;
        if (hs) i++;
      end
      sc_valid = 1'b0;
      check_eq("sc_loaded", i, NUM_EXP);
      if (start_in_exp) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (abort) begin
        t = 0;
        while (cnt_m[1] < 3 && t < 100) begin
          @(posedge clk); #1; t++;
        end
        check_eq("div_reached", cnt_m[1], 3);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_outputs",
                 {iss_valid, iss_mode, iss_data, iss_psum, busy, done, err, sc_ready, ex_ready}, 0);
        repeat (4) @(posedge clk);
        check_eq("abort_no_done", done_cnt, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_idle", {busy, done, iss_valid, sc_ready, ex_ready}, 0);
        return;
      end
    end
    i = 0; t = 0;
    while (i < n && t < 500) begin
      case (vpat)
        0:       v = 1'b1;
        1:       v = (t % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      ex_valid = v;
      ex_data  = v ? job_ed[i] : DW'($urandom_range(0, 65535));
      ex_psum  = v ? job_ep[i] : DW'($urandom_range(0, 65535));
      ex_last  = v && (i == n - 1);
      hs = v && ex_ready;
      @(posedge clk); #1; t++;
      if (hs) i++;
    end
    ex_valid = 1'b0; ex_last = 1'b0;
    check_eq("ex_sent", i, n);
    t = 0;
    while (done_cnt == 0 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_once", done_cnt, 1);
    check_eq("done_after_last_beat", done_cyc - last_iss_cyc, 1);
    check_eq("err", err, !gelu && (n % NUM_EXP != 0));
    check_eq("sb_empty", sbq.size(), 0);
    check_eq("busy_idle", busy, 0);
    if (gelu) begin
      check_eq("gelu_beats", cnt_m[2], n);
      check_eq("sc_ready_gelu", sc_rdy_bad, 0);
    end else begin
      check_eq("exp_beats", cnt_m[0], NUM_EXP);
      check_eq("exp_back_to_back", last_c[0] - first_c[0], NUM_EXP - 1);
      check_eq("sum_gap", first_c[1] - last_c[0], ADD_LAT + 1);
      check_eq("div_beats", cnt_m[1], NUM_EXP);
      check_eq("div_back_to_back", last_c[1] - first_c[1], NUM_EXP - 1);
      check_eq("div_gap", first_exrdy - last_c[1], MUL_LAT);
      check_eq("agg_beats", cnt_m[3], n);
    end
  endtask

  initial begin
    #12;
    check_eq("reset_outputs",
             {iss_valid, iss_mode, iss_data, iss_psum, busy, done, err, sc_ready, ex_ready}, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_outputs", {iss_valid, busy, done, err, sc_ready, ex_ready}, 0);

    for (int i = 0; i < NUM_EXP; i++) job_sc[i] = 16'h3C00 + 16'(i);
    for (int i = 0; i < MAX_EX; i++) begin
      job_ed[i] = 16'(i);
      job_ep[i] = 16'h1000 + 16'(i);
    end
    run_job(0, 16, 1, 0, 0, 0);

    fill_rand();
    run_job(0, 5, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 check_eq("err_sticky", err, 1);

    for (int i = 0; i < 4; i++) job_ed[i] = 16'h0011 + 16'(i);
    run_job(1, 4, 0, 0, 0, 0);

    fill_rand();
    run_job(0, 8, 2, 1, 1, 0);

    fill_rand();
    run_job(0, 8, 0, 0, 0, 1);

    fill_rand();
    run_job(0, 16, 0, 0, 0, 0);

    repeat (4) begin
      bit g;
      g = bit'($urandom_range(0, 1));
      fill_rand();
      run_job(g, $urandom_range(1, 24), 2, 1, bit'($urandom_range(0, 1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
